debounce_multi: RTL and testbench

//  NCH-channel debouncer for push-buttons/switches: the successor to the single-channel debouncer.
//  - Each channel: 2-FF synchroniser, then its own stability counter.
//  - clean[i] takes a new value only after the synchronised input has held it for NDELAY counted ticks.
//  - Also gives one-cycle rise/fall pulses per channel, so downstream FSMs need no edge detectors.
//  - Optional shared tick enable lets one prescaler slow every counter.

---
 rtl/debounce_multi.sv | 82 ++++++++
 tb/tb_debounce_multi.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel push-button/switch debouncer. Each channel has a 2-FF synchroniser, its own
// saturating stability counter, a registered clean level and one-cycle rise/fall pulses.
module debounce_multi #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned NDELAY = 300000,
  parameter int unsigned NBITS  = 19,
  parameter logic        INIT   = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic [NCH-1:0] noisy,
  output logic [NCH-1:0] clean,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic           busy
);

  localparam logic [NBITS-1:0] MaxCnt = NBITS'(NDELAY);

  logic [NCH-1:0]   s1_q, s1_d;
  logic [NCH-1:0]   s2_q, s2_d;
  logic [NCH-1:0]   xnew_q, xnew_d;
  logic [NCH-1:0]   clean_q, clean_d;
  logic [NCH-1:0]   rise_q, rise_d;
  logic [NCH-1:0]   fall_q, fall_d;
  logic             busy_q, busy_d;
  logic [NBITS-1:0] cnt_q [NCH];
  logic [NBITS-1:0] cnt_d [NCH];

  always_comb begin
    s1_d    = noisy;
    s2_d    = s1_q;
    xnew_d  = xnew_q;
    clean_d = clean_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      // A change of the synchronised input always restarts the count, even with tick low.
      if (s2_q[i] != xnew_q[i]) begin
        xnew_d[i] = s2_q[i];
        cnt_d[i]  = '0;
      end else if (tick && (cnt_q[i] == MaxCnt) && (clean_q[i] != xnew_q[i])) begin
        clean_d[i] = xnew_q[i];
      end else if (tick && (cnt_q[i] != MaxCnt)) begin
        cnt_d[i] = cnt_q[i] + NBITS'(1);
      end
    end
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
    busy_d = |(xnew_d ^ clean_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= {NCH{INIT}};
      s2_q    <= {NCH{INIT}};
      xnew_q  <= {NCH{INIT}};
      clean_q <= {NCH{INIT}};
      rise_q  <= '0;
      fall_q  <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      xnew_q  <= xnew_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: tasks queue the pulses they expect, a negedge monitor pops and
// compares every pulse the DUT emits, and each task checks levels inline.
module tb_debounce_multi;

  localparam int unsigned NCH    = 2;
  localparam int unsigned NDELAY = 4;
  localparam int unsigned NBITS  = 3;
  localparam int          Lat    = NDELAY + 3;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic           tick  = 1'b1;
  logic [NCH-1:0] noisy = '0;
  logic [NCH-1:0] clean;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic           busy;

  debounce_multi #(
    .NCH    (NCH),
    .NDELAY (NDELAY),
    .NBITS  (NBITS),
    .INIT   (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .noisy (noisy),
    .clean (clean),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             at;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  errors = 0;
  int  checks = 0;

  // Every pulse the DUT produces must match the head of the expected-event queue.
  always @(negedge clk) begin
    if (!reset && (rise != '0 || fall != '0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: at edge %0d got rise=%b fall=%b, required none",
                 cyc, rise, fall);
      end else begin
        ev = exp_q.pop_front();
        if (ev.at != cyc || ev.rise !== rise || ev.fall !== fall) begin
          errors++;
          $display("FAIL pulse: got edge %0d rise=%b fall=%b, required edge %0d rise=%b fall=%b",
                   cyc, rise, fall, ev.at, ev.rise, ev.fall);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    noisy = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    noisy = 2'b11;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy_before: got %b, required 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (clean !== 2'b00) begin
      errors++;
      $display("FAIL reset_clean: got %b, required 00", clean);
    end
    checks++;
    if (rise !== 2'b00 || fall !== 2'b00) begin
      errors++;
      $display("FAIL reset_pulses: got rise=%b fall=%b, required 00/00", rise, fall);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
    noisy = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (clean !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: got clean=%b busy=%b, required 00/0", clean, busy);
    end
  endtask

  task automatic test_clean_step();
    int k;
    @(negedge clk);
    noisy[0] = 1'b1;
    k = cyc + 1;
    exp_q.push_back('{at: k + Lat, rise: 2'b01, fall: 2'b00});
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== ((cyc >= k + 2) && (cyc <= k + 6))) begin
        errors++;
        $display("FAIL step_busy: at edge %0d got %b, required %b", cyc - k, busy,
                 ((cyc >= k + 2) && (cyc <= k + 6)));
      end
      checks++;
      if (clean[0] !== (cyc >= k + Lat)) begin
        errors++;
        $display("FAIL step_clean: at edge %0d got %b, required %b", cyc - k, clean[0],
                 (cyc >= k + Lat));
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL step_missing: got %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    int k;
    @(negedge clk);
    noisy[0] = 1'b0;
    k = cyc + 1;
    exp_q.push_back('{at: k + Lat, rise: 2'b00, fall: 2'b01});
    repeat (10) @(negedge clk);
    noisy[0] = 1'b1;
    repeat (2) @(negedge clk);
    noisy[0] = 1'b0;
    repeat (2) @(negedge clk);
    noisy[0] = 1'b1;
    k = cyc + 1;
    exp_q.push_back('{at: k + Lat, rise: 2'b01, fall: 2'b00});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (clean[0] !== (cyc >= k + Lat)) begin
        errors++;
        $display("FAIL bounce_clean: at edge %0d got %b, required %b", cyc - k, clean[0],
                 (cyc >= k + Lat));
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_missing: got %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_short_glitch();
    int k;
    @(negedge clk);
    noisy[1] = 1'b1;
    k = cyc + 1;
    exp_q.push_back('{at: k + Lat, rise: 2'b10, fall: 2'b00});
    repeat (10) @(negedge clk);
    noisy[1] = 1'b0;
    repeat (3) @(negedge clk);
    noisy[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (clean[1] !== 1'b1) begin
        errors++;
        $display("FAIL glitch_clean: got %b, required 1", clean[1]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_missing: got %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_tick_gating();
    int k;
    int e;
    int n;
    @(negedge clk);
    noisy[0] = 1'b0;
    k = cyc + 1;
    tick = ((k % 4) == 0);
    // Clean follows on the fifth tick edge after the xnew update at k+2.
    e = k + 3;
    n = 0;
    while (n < NDELAY + 1) begin
      if ((e % 4) == 0) n++;
      if (n < NDELAY + 1) e++;
    end
    exp_q.push_back('{at: e, rise: 2'b00, fall: 2'b01});
    while (cyc < e + 2) begin
      @(negedge clk);
      tick = (((cyc + 1) % 4) == 0);
      checks++;
      if (clean[0] !== (cyc < e)) begin
        errors++;
        $display("FAIL tick_clean: at edge %0d got %b, required %b", cyc - k, clean[0],
                 (cyc < e));
      end
    end
    tick = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL tick_missing: got %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    noisy = 2'b00;
    k = cyc + 1;
    exp_q.push_back('{at: k + Lat, rise: 2'b00, fall: 2'b10});
    repeat (10) @(negedge clk);
    noisy[0] = 1'b1;
    k = cyc + 1;
    exp_q.push_back('{at: k + Lat, rise: 2'b01, fall: 2'b00});
    exp_q.push_back('{at: k + 2 + Lat, rise: 2'b10, fall: 2'b00});
    repeat (2) @(negedge clk);
    noisy[1] = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (clean !== 2'b11 || busy !== 1'b0) begin
      errors++;
      $display("FAIL indep_final: got clean=%b busy=%b, required 11/0", clean, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL indep_missing: got %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_short_glitch();
    test_tick_gating();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
